hazard_controller: RTL

Pipeline hazard and stall sequencer for the 5-stage RISC-V core. It sits beside the forwarding unit and handles the hazards forwarding cannot resolve:
- load-use stalls, bubbled into ID/EX;
- multi-cycle MUL/DIV occupancy of EX, holding IF/ID/EX and bubbling EX/MEM;
- taken-branch flushes of IF/ID and ID/EX.

It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_controller_if.sv | 38 +++
 rtl/hazard_controller.sv | 112 +++++++++++
 2 files changed

// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - pipeline-side hazard/stall control bundle
interface hazard_controller_if #(
   parameter int STAT_W = 16
);
   logic              ID_EX_MemRead;
   logic [4:0]        ID_EX_RegisterRd;
   logic              ID_EX_MultiCycle;
   logic [4:0]        IF_ID_RegisterRs1;
   logic [4:0]        IF_ID_RegisterRs2;
   logic              IF_ID_UsesRs1;
   logic              IF_ID_UsesRs2;
   logic              BranchTaken;
   logic              PCWrite;
   logic              IF_ID_Write;
   logic              IF_ID_Flush;
   logic              ID_EX_Flush;
   logic              ID_EX_Hold;
   logic              EX_MEM_Bubble;
   logic              muldiv_start;
   logic              muldiv_done;
   logic [STAT_W-1:0] stall_cycles;

   modport master (
      output ID_EX_MemRead, ID_EX_RegisterRd, ID_EX_MultiCycle,
             IF_ID_RegisterRs1, IF_ID_RegisterRs2, IF_ID_UsesRs1, IF_ID_UsesRs2,
             BranchTaken,
      input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold,
             EX_MEM_Bubble, muldiv_start, muldiv_done, stall_cycles
   );

   modport slave (
      input  ID_EX_MemRead, ID_EX_RegisterRd, ID_EX_MultiCycle,
             IF_ID_RegisterRs1, IF_ID_RegisterRs2, IF_ID_UsesRs1, IF_ID_UsesRs2,
             BranchTaken,
      output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold,
             EX_MEM_Bubble, muldiv_start, muldiv_done, stall_cycles
   );
endinterface

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - load-use / MUL-DIV / branch hazard sequencer
module hazard_controller #(
   parameter int MULDIV_LATENCY = 4,
   parameter int CNT_W          = 8,
   parameter int STAT_W         = 16
) (
   input  logic               clk,
   input  logic               reset,
   hazard_controller_if.slave hz
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(MULDIV_LATENCY - 2);
   localparam bit               SKIP_BUSY  = (MULDIV_LATENCY == 2);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;

   logic load_use;
   logic pc_write, if_id_write, if_id_flush, id_ex_flush;
   logic id_ex_hold, ex_mem_bubble, muldiv_start, muldiv_done;

   always_comb begin
      load_use = hz.ID_EX_MemRead && (hz.ID_EX_RegisterRd != 5'd0) &&
                 ((hz.IF_ID_UsesRs1 && (hz.ID_EX_RegisterRd == hz.IF_ID_RegisterRs1)) ||
                  (hz.IF_ID_UsesRs2 && (hz.ID_EX_RegisterRd == hz.IF_ID_RegisterRs2)));
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      id_ex_hold    = 1'b0;
      ex_mem_bubble = 1'b0;
      muldiv_start  = 1'b0;
      muldiv_done   = 1'b0;

      if (!reset) begin
         case (state_q)
            IDLE: begin
               if (hz.BranchTaken) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (hz.ID_EX_MultiCycle) begin
                  muldiv_start  = 1'b1;
                  pc_write      = 1'b0;
                  if_id_write   = 1'b0;
                  id_ex_hold    = 1'b1;
                  ex_mem_bubble = 1'b1;
                  cnt_d         = CNT_INIT;
                  state_d       = SKIP_BUSY ? DONE : BUSY;
               end else if (load_use) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end
            BUSY: begin
               // Freeze IF/ID/EX while the unit works; branch and load-use wait.
               pc_write      = 1'b0;
               if_id_write   = 1'b0;
               id_ex_hold    = 1'b1;
               ex_mem_bubble = 1'b1;
               cnt_d         = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE: begin
               muldiv_done = 1'b1;
               state_d     = IDLE;
               if (hz.BranchTaken) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (load_use) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      stall_cycles_d = stall_cycles_q;
      if (!pc_write && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign hz.PCWrite       = pc_write;
   assign hz.IF_ID_Write   = if_id_write;
   assign hz.IF_ID_Flush   = if_id_flush;
   assign hz.ID_EX_Flush   = id_ex_flush;
   assign hz.ID_EX_Hold    = id_ex_hold;
   assign hz.EX_MEM_Bubble = ex_mem_bubble;
   assign hz.muldiv_start  = muldiv_start;
   assign hz.muldiv_done   = muldiv_done;
   assign hz.stall_cycles  = stall_cycles_q;
endmodule
